// File: rtl/pipe_hold_ctrl.sv
// rtl/pipe_hold_ctrl.sv - pipeline hold/flush/redirect sequencer for the 5-stage core
// Hold/flush bit index = stage: [0]pc [1]if_id [2]id_ex [3]ex_mem [4]mem_wb.
module pipe_hold_ctrl #(
   parameter int MCYC_MAX = 64,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [4:0]       id_rs1_addr_i,
   input  logic [4:0]       id_rs2_addr_i,
   input  logic             id_rs1_ren_i,
   input  logic             id_rs2_ren_i,
   input  logic [4:0]       ex_rd_addr_i,
   input  logic             ex_regs_wen_i,
   input  logic             ex_is_load_i,
   input  logic [31:0]      ex_instaddr_i,
   input  logic             ex_jump_en_i,
   input  logic             ex_prd_jump_en_i,
   input  logic [31:0]      ex_jump_addr_i,
   input  logic             ex_mcyc_start_i,
   input  logic             ex_mcyc_done_i,
   input  logic             mem_req_i,
   input  logic             mem_ack_i,
   output logic [4:0]       hold_en_o,
   output logic [4:0]       flush_o,
   output logic             jump_en_o,
   output logic [31:0]      jump_addr_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic             err_o
);

   localparam int MW = $clog2(MCYC_MAX) + 1;

   typedef enum logic [1:0] {S_IDLE, S_MEMW, S_MCYC} state_t;

   state_t           r_state;
   logic [MW-1:0]    r_mcyc_cnt;
   logic [CNT_W-1:0] r_stall_cnt;
   logic             r_err;

   logic w_mem_wait;
   logic w_mcyc_busy;
   logic w_timeout;
   logic w_mispredict;
   logic w_rs1_hit;
   logic w_rs2_hit;
   logic w_load_use;

   assign w_mem_wait  = ((r_state == S_MEMW) && !mem_ack_i) ||
                        ((r_state == S_IDLE) && mem_req_i && !mem_ack_i);
   assign w_mcyc_busy = ((r_state == S_MCYC) && !ex_mcyc_done_i) ||
                        ((r_state == S_IDLE) && ex_mcyc_start_i && !ex_mcyc_done_i);
   assign w_timeout   = (r_state == S_MCYC) && !ex_mcyc_done_i &&
                        (r_mcyc_cnt == MW'(MCYC_MAX - 1));

   // EX is frozen during a wait, so a pending mispredict simply re-evaluates once the hold drops.
   assign w_mispredict = ex_jump_en_i != ex_prd_jump_en_i;
   assign w_rs1_hit    = id_rs1_ren_i && (id_rs1_addr_i == ex_rd_addr_i);
   assign w_rs2_hit    = id_rs2_ren_i && (id_rs2_addr_i == ex_rd_addr_i);
   assign w_load_use   = ex_is_load_i && ex_regs_wen_i && (ex_rd_addr_i != 5'd0) &&
                         (w_rs1_hit || w_rs2_hit);

   always_comb begin
      hold_en_o   = 5'b00000;
      flush_o     = 5'b00000;
      jump_en_o   = 1'b0;
      jump_addr_o = 32'd0;
      if (!rstn) begin
         hold_en_o = 5'b00000;
      end else if (w_mem_wait) begin
         hold_en_o = 5'b11111;
      end else if (w_mcyc_busy) begin
         hold_en_o = 5'b00111;
         flush_o   = 5'b01000;
      end else if (w_mispredict) begin
         jump_en_o   = 1'b1;
         flush_o     = 5'b00110;
         jump_addr_o = ex_jump_en_i ? ex_jump_addr_i : ex_instaddr_i + 32'd4;
      end else if (w_load_use) begin
         hold_en_o = 5'b00011;
         flush_o   = 5'b00100;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= S_IDLE;
         r_mcyc_cnt  <= '0;
         r_stall_cnt <= '0;
         r_err       <= 1'b0;
      end else begin
         if ((hold_en_o != 5'b00000) && (r_stall_cnt != {CNT_W{1'b1}}))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         case (r_state)
            S_IDLE: begin
               if (mem_req_i && !mem_ack_i) begin
                  r_state <= S_MEMW;
               end else if (ex_mcyc_start_i && !ex_mcyc_done_i) begin
                  r_state    <= S_MCYC;
                  r_mcyc_cnt <= '0;
               end
            end
            S_MEMW: begin
               if (mem_ack_i)
                  r_state <= S_IDLE;
            end
            S_MCYC: begin
               if (ex_mcyc_done_i) begin
                  r_state <= S_IDLE;
               end else if (w_timeout) begin
                  r_state <= S_IDLE;
                  r_err   <= 1'b1;
               end else begin
                  r_mcyc_cnt <= r_mcyc_cnt + MW'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign stall_cnt_o = r_stall_cnt;
   assign err_o       = r_err;

endmodule

// File: doc/pipe_hold_ctrl.md
Name: pipe_hold_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core.
- Drives the per-stage hold vector consumed by pc, if_id, id_ex, ex_mem and mem_wb (bit index = stage), plus per-stage flush (bubble insert).
- Resolves load-use hazards, multi-cycle EX ops (div), data-memory wait states and branch-prediction mispredicts into one prioritized stall/flush/redirect decision.
- Holds a stall performance counter.

Parameters:
MCYC_MAX, 64, EX multi-cycle timeout in cycles before err_o is set
CNT_W, 32, width of stall performance counter

Ports:
clk  in  1  core clock
rstn  in  1  asynchronous active-low reset
id_rs1_addr_i  in  5  rs1 index of instruction in ID
id_rs2_addr_i  in  5  rs2 index of instruction in ID
id_rs1_ren_i  in  1  ID instruction reads rs1
id_rs2_ren_i  in  1  ID instruction reads rs2
ex_rd_addr_i  in  5  rd of instruction in EX
ex_regs_wen_i  in  1  EX instruction writes rd
ex_is_load_i  in  1  EX instruction is a load
ex_instaddr_i  in  32  PC of EX instruction
ex_jump_en_i  in  1  EX resolved branch/jump taken
ex_prd_jump_en_i  in  1  prediction carried with EX instruction
ex_jump_addr_i  in  32  resolved target
ex_mcyc_start_i  in  1  EX begins a multi-cycle op (pulse)
ex_mcyc_done_i  in  1  multi-cycle op result valid (pulse)
mem_req_i  in  1  MEM stage data access request
mem_ack_i  in  1  data memory response
hold_en_o  out  5  [0]pc [1]if_id [2]id_ex [3]ex_mem [4]mem_wb hold
flush_o  out  5  same bit map, stage register loads NOP/zero
jump_en_o  out  1  redirect fetch this cycle
jump_addr_o  out  32  redirect target
stall_cnt_o  out  CNT_W  cycles with hold_en_o != 0
err_o  out  1  sticky multi-cycle timeout

Behaviour:
- Reset (rstn=0, async): state=IDLE, mcyc_cnt=0, stall_cnt_o=0, err_o=0. Outputs are combinational from state/inputs. With idle inputs: hold_en_o=0, flush_o=0, jump_en_o=0, jump_addr_o=0.
- FSM states:
  - IDLE -> MEMW when mem_req_i & !mem_ack_i.
  - IDLE -> MCYC when ex_mcyc_start_i & !ex_mcyc_done_i (and not entering MEMW).
  - MEMW -> IDLE on mem_ack_i.
  - MCYC -> IDLE on ex_mcyc_done_i, or when mcyc_cnt==MCYC_MAX-1 (sets err_o; err_o clears only on reset).
- mcyc_cnt: cleared on MCYC entry, +1 per MCYC cycle.
- Per-cycle decision, highest priority first:
  1. MEMW, or IDLE with mem_req_i & !mem_ack_i: hold=5'b11111, flush=0, jump_en_o=0. MEMW is exited combinationally in the ack cycle: hold=0.
  2. MCYC, or IDLE with start & !done: hold=5'b00111, flush=5'b01000 (bubble into ex_mem). In the done cycle: hold=0.
  3. Mispredict (ex_jump_en_i != ex_prd_jump_en_i, state IDLE): jump_en_o=1, flush=5'b00110, hold=0.
     - jump_addr_o = ex_jump_en_i ? ex_jump_addr_i : ex_instaddr_i+32'd4, modulo 2^32 (0xFFFFFFFC+4 -> 0).
  4. Load-use: ex_is_load_i & ex_regs_wen_i & ex_rd_addr_i!=0 & ((id_rs1_ren_i & rs1==rd) | (id_rs2_ren_i & rs2==rd)) -> hold=5'b00011, flush=5'b00100. Exactly one stall cycle.
  5. Otherwise hold=0, flush=0.
- A mispredict coincident with a memory wait is not lost. EX is frozen, so it is re-evaluated and issued in the first non-held cycle.
- Mispredict suppresses load-use in the same cycle; the flush removes the dependent instruction.
- rd==x0 never causes a stall.
- jump_addr_o=0 whenever jump_en_o=0.
- stall_cnt_o increments when hold_en_o!=0 and saturates at all-ones.
- Reset asserted mid-MEMW/MCYC returns to IDLE immediately; outputs release in the same cycle.

Test Plan:
- Load-use: EX lw rd=5, ID add rs1=5 -> one cycle hold=00011, flush=00100, then 0; stall_cnt_o=1. Repeat with rd=0 -> no stall.
- Mispredict: predicted not-taken, taken, target 0x80 -> jump_en_o=1, jump_addr_o=0x80, flush=00110. Predicted taken, not taken, ex_instaddr_i=0xFFFFFFFC -> jump_addr_o=0x0.
- Div: start pulse, done 33 cycles later -> hold=00111 for 33 cycles, 0 on the done cycle; err_o=0.
- Timeout: start, never done, MCYC_MAX=64 -> err_o=1 after 64 cycles, state IDLE, hold released.
- Memory wait + mispredict: mem_req_i held 3 cycles without ack while the mispredict is present -> hold=11111, jump_en_o=0 for 3 cycles. Ack cycle -> hold=0, jump_en_o=1.
- Reset in MEMW: rstn low for 1 cycle -> hold_en_o=0, stall_cnt_o=0 immediately (asynchronous).
